// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, ALUOp codes, state encoding and control bundle
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Shared with the ALU-control decoder on the consumer side
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

    // True for every opcode the sequencer knows how to execute
    function automatic logic op_known(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// rtl/mc_out_decode.sv - combinational state-to-control-output decoder
module mc_out_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t          state,
    input  logic            mem_ready,
    input  logic [OPW-1:0]  opcode,
    output ctrl_t           ctrl
);

    logic [5:0] op6;
    assign op6 = 6'(opcode);

    // Moore decode; only FETCH (mem_ready) and DECODE (opcode) look past the state
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = ~op_known(op6);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = 2'b01;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JEX: begin
                ctrl.pc_src   = 2'b10;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle MIPS main control FSM
module mc_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic [1:0]      ALUOp,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSrc,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            Branch,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            illegal,
    output logic [STW-1:0]  state_o
);

    state_t     state;
    ctrl_t      ctrl;
    logic [5:0] op6;

    assign op6 = 6'(opcode);

    // State register and next-state selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:   state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (op6 == OP_LW || op6 == OP_SW) state <= S_MEMADR;
                    else if (op6 == OP_RTYPE)         state <= S_RTYPEEX;
                    else if (op6 == OP_BEQ)           state <= S_BEQEX;
                    else if (op6 == OP_ADDI)          state <= S_ADDIEX;
                    else if (op6 == OP_J)             state <= S_JEX;
                    else                              state <= S_FETCH;
                end
                S_MEMADR:  state <= (op6 == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:   state <= S_FETCH;
                S_MEMWR:   state <= mem_ready ? S_FETCH : S_MEMWR;
                S_RTYPEEX: state <= S_RTYPEWB;
                S_RTYPEWB: state <= S_FETCH;
                S_BEQEX:   state <= S_FETCH;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ADDIWB:  state <= S_FETCH;
                S_JEX:     state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end

    mc_out_decode #(
        .OPW (OPW)
    ) u_out_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (ctrl)
    );

    // Selects pass straight through; reset already parks the state in FETCH
    assign ALUOp    = ctrl.alu_op;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSrc    = ctrl.pc_src;
    assign IorD     = ctrl.iord;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;

    // Strobes are masked while reset is held so FETCH's MemRead cannot leak out
    assign MemRead  = ctrl.mem_read  & rst_n;
    assign MemWrite = ctrl.mem_write & rst_n;
    assign IRWrite  = ctrl.ir_write  & rst_n;
    assign PCWrite  = ctrl.pc_write  & rst_n;
    assign Branch   = ctrl.branch    & rst_n;
    assign RegWrite = ctrl.reg_write & rst_n;
    assign illegal  = ctrl.illegal   & rst_n;

    assign state_o  = STW'(state);

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle MIPS main control FSM.
- Decodes the instruction opcode and sequences the datapath through its steps.
- Drives ALUOp into the existing ALU-control decoder, so this block is the producer end of the ALUOp interface.
- Also drives every mux select and write strobe, and waits on a memory-ready handshake.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  instruction[31:26]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- ALUOp  out  2  00=add, 01=sub, 10=use funct.
- ALUSrcA  out  1  0=PC, 1=regA.
- ALUSrcB  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2.
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- IorD  out  1  0=PC address, 1=ALUOut address.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite, PCWrite, Branch  out  1 each  IR load, unconditional PC load, PC load qualified by zero.
- RegDst, MemtoReg, RegWrite  out  1 each  register-file controls.
- illegal  out  1  unknown opcode seen in DECODE.
- state_o  out  STW  current state, for debug.

Behaviour:
- Moore machine: all outputs are decoded from the registered state.
  - Exception: IRWrite and PCWrite in FETCH are also ANDed with mem_ready.
  - Exception: illegal in DECODE also depends on opcode.
- Reset: rst_n low forces state=FETCH asynchronously.
  - While rst_n is low, every strobe (MemRead, MemWrite, IRWrite, PCWrite, Branch, RegWrite) and illegal is 0.
  - All selects are 0, except ALUSrcB=01, which is the FETCH value.
- Reset mid-instruction abandons the instruction; the first edge after release evaluates FETCH.
- States and per-state outputs (unlisted outputs are 0):
  - FETCH(0): MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready.
    - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcB=11, ALUOp=00 (branch target).
    - opcode 100011(lw) or 101011(sw) -> MEMADR.
    - opcode 000000 -> RTYPEEX.
    - opcode 000100 -> BEQEX.
    - opcode 001000 -> ADDIEX.
    - opcode 000010 -> JEX.
    - Any other opcode -> illegal=1 for this cycle, then FETCH.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(3): IorD=1, MemRead=1. Holds until mem_ready, then MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Holds until mem_ready, then FETCH.
  - RTYPEEX(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RTYPEWB.
  - RTYPEWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
  - BEQEX(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next is FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
  - JEX(11): PCSrc=10, PCWrite=1. Next is FETCH.
- Encodings 12-15 are unreachable; if entered, outputs are all-zero and the next state is FETCH.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE and MEMADR; it must remain stable from DECODE until the instruction returns to FETCH (guaranteed by the IR).
- A strobe is never asserted in two consecutive states unless listed for both.
- A state that waits on mem_ready asserts its strobe continuously until completion.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, shared with the ALU-control decoder;
  - the state encoding constants S_FETCH..S_JEX.
- One natural sub-module, mc_out_decode: purely combinational, state (plus mem_ready and opcode) -> control outputs.
- The top level keeps the state register and next-state logic.

Test Plan:
- Reset: assert rst_n=0 mid-MEMRD with mem_ready=1 -> state_o=0 immediately, all strobes 0. Release -> FETCH with MemRead=1, ALUSrcB=01.
- R-type: opcode=000000, mem_ready=1 -> states 0,1,6,7,0. ALUOp=10 only in state 6. RegWrite=1 and RegDst=1 in state 7 only.
- lw with wait: opcode=100011, mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. MemRead and IorD held through all MEMRD cycles. RegWrite with MemtoReg=1 once.
- beq: opcode=000100 -> states 0,1,8,0. In state 8: ALUOp=01, Branch=1, PCSrc=01, PCWrite=0.
- Fetch stall: mem_ready=0 for 3 cycles after reset -> state stays 0, IRWrite=PCWrite=0. IRWrite=PCWrite=1 only in the cycle mem_ready=1, then DECODE.
- Illegal opcode: opcode=111111 -> illegal=1 for exactly one cycle in DECODE. No strobe asserted. Next state FETCH.
